// File: rtl/cmplx_mul_if.sv
// cmplx_mul_if: operand, configuration and product streams of cmplx_mul.
// slave is the multiplier side, master the producer/consumer side.
interface cmplx_mul_if #(
   parameter int IW = 16,
   parameter int OW = 28
);
   logic signed [IW-1:0] A_Re;
   logic signed [IW-1:0] A_Im;
   logic signed [IW-1:0] B_Re;
   logic signed [IW-1:0] B_Im;
   logic                 A_tvalid;
   logic                 A_tfirst;
   logic                 A_tlast;
   logic                 A_tready;
   logic                 Cfg_tvalid;
   logic [3:0]           Cfg_modulation;
   logic                 Cfg_tready;
   logic                 CfgOut_tvalid;
   logic [3:0]           CfgOut_modulation;
   logic signed [OW-1:0] C_Re;
   logic signed [OW-1:0] C_Im;
   logic                 C_tvalid;
   logic                 C_tfirst;
   logic                 C_tlast;
   logic                 C_tready;
   logic                 CmplxMul_Error;

   modport slave (
      input  A_Re, A_Im, B_Re, B_Im,
      input  A_tvalid, A_tfirst, A_tlast,
      output A_tready,
      input  Cfg_tvalid, Cfg_modulation,
      output Cfg_tready,
      output CfgOut_tvalid, CfgOut_modulation,
      output C_Re, C_Im,
      output C_tvalid, C_tfirst, C_tlast,
      input  C_tready,
      output CmplxMul_Error
   );

   modport master (
      output A_Re, A_Im, B_Re, B_Im,
      output A_tvalid, A_tfirst, A_tlast,
      input  A_tready,
      output Cfg_tvalid, Cfg_modulation,
      input  Cfg_tready,
      input  CfgOut_tvalid, CfgOut_modulation,
      input  C_Re, C_Im,
      input  C_tvalid, C_tfirst, C_tlast,
      output C_tready,
      input  CmplxMul_Error
   );
endinterface

// File: rtl/cmplx_mul.sv
// cmplx_mul: 3-stage streaming complex multiplier C = A*B, saturating.
// Define CMPLXMUL_ROUND_EN for round half-up; default truncates.
module cmplx_mul #(
   parameter int InputBitWidth         = 16,
   parameter int OutputBitWidth        = 28,
   parameter int InputFractionalPoint  = 11,
   parameter int OutputFractionalPoint = 11
) (
   input logic        Clk,
   input logic        Reset,
   cmplx_mul_if.slave bus
);
   localparam int IW = InputBitWidth;
   localparam int OW = OutputBitWidth;
   localparam int S  = 2 * InputFractionalPoint
                     - OutputFractionalPoint;
   localparam int SR = (S > 0) ? S : 0;
   localparam int SL = (S < 0) ? -S : 0;
   localparam int PW = 2 * IW;
   localparam int W  = PW + 2 + SL;
   localparam int WM = (W > OW) ? W : OW;

   typedef logic signed [IW-1:0] in_t;
   typedef logic signed [PW-1:0] prod_t;
   typedef logic signed [W-1:0]  wide_t;
   typedef logic signed [WM-1:0] ext_t;
   typedef logic signed [OW-1:0] out_t;

   localparam ext_t MAXV = {{(WM-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam ext_t MINV = {{(WM-OW+1){1'b1}}, {(OW-1){1'b0}}};
`ifdef CMPLXMUL_ROUND_EN
   localparam wide_t RND = (SR > 0) ?
      (wide_t'(1) <<< ((SR > 0) ? SR - 1 : 0)) : '0;
`else
   localparam wide_t RND = '0;
`endif

   logic       en;
   logic       acc;
   logic       cfg_acc;
   logic       live_q;
   logic       open_q, open_d;
   logic       err_q, err_d;
   logic [3:0] cfg_q, cfg_d;

   in_t        ar_q, ai_q, br_q, bi_q;
   logic       v1_q, f1_q, l1_q;
   logic [3:0] m1_q;

   prod_t      rr_q, ii_q, ri_q, ir_q;
   logic       v2_q, f2_q, l2_q;
   logic [3:0] m2_q;

   out_t       cre_q, cim_q, cre_d, cim_d;
   logic       cv_q, cf_q, cl_q, ocv_q;
   logic [3:0] om_q;

   wide_t      re_w, im_w;
   ext_t       re_x, im_x;
   logic       sat_re, sat_im;

   assign en      = bus.C_tready | ~cv_q;
   assign acc     = bus.A_tvalid & en & live_q;
   assign cfg_acc = bus.Cfg_tvalid & ~open_q & live_q;

   assign bus.A_tready          = en & live_q;
   assign bus.Cfg_tready        = ~open_q & live_q;
   assign bus.C_Re              = cre_q;
   assign bus.C_Im              = cim_q;
   assign bus.C_tvalid          = cv_q;
   assign bus.C_tfirst          = cf_q;
   assign bus.C_tlast           = cl_q;
   assign bus.CfgOut_tvalid     = ocv_q;
   assign bus.CfgOut_modulation = om_q;
   assign bus.CmplxMul_Error    = err_q;

   // Same-cycle config word belongs to the beat accepted with it.
   always_comb begin
      cfg_d = cfg_acc ? bus.Cfg_modulation : cfg_q;
   end

   always_comb begin
      re_w   = wide_t'(rr_q) - wide_t'(ii_q);
      im_w   = wide_t'(ri_q) + wide_t'(ir_q);
      re_w   = (re_w + RND) <<< SL;
      im_w   = (im_w + RND) <<< SL;
      re_w   = re_w >>> SR;
      im_w   = im_w >>> SR;
      re_x   = ext_t'(re_w);
      im_x   = ext_t'(im_w);
      sat_re = (re_x > MAXV) || (re_x < MINV);
      sat_im = (im_x > MAXV) || (im_x < MINV);
      cre_d  = re_x[OW-1:0];
      cim_d  = im_x[OW-1:0];
      if (sat_re)
         cre_d = (re_x > MAXV) ? MAXV[OW-1:0] : MINV[OW-1:0];
      if (sat_im)
         cim_d = (im_x > MAXV) ? MAXV[OW-1:0] : MINV[OW-1:0];
   end

   always_comb begin
      open_d = open_q;
      err_d  = err_q;
      if (acc) begin
         if (bus.A_tfirst & open_q)
            err_d = 1'b1;
         if (~bus.A_tfirst & ~open_q)
            err_d = 1'b1;
         if (bus.A_tlast)
            open_d = 1'b0;
         else if (bus.A_tfirst)
            open_d = 1'b1;
      end
      if (en & v2_q & (sat_re | sat_im))
         err_d = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         live_q <= 1'b0;
         open_q <= 1'b0;
         err_q  <= 1'b0;
         cfg_q  <= '0;
         ar_q   <= '0;
         ai_q   <= '0;
         br_q   <= '0;
         bi_q   <= '0;
         v1_q   <= 1'b0;
         f1_q   <= 1'b0;
         l1_q   <= 1'b0;
         m1_q   <= '0;
         rr_q   <= '0;
         ii_q   <= '0;
         ri_q   <= '0;
         ir_q   <= '0;
         v2_q   <= 1'b0;
         f2_q   <= 1'b0;
         l2_q   <= 1'b0;
         m2_q   <= '0;
         cre_q  <= '0;
         cim_q  <= '0;
         cv_q   <= 1'b0;
         cf_q   <= 1'b0;
         cl_q   <= 1'b0;
         ocv_q  <= 1'b0;
         om_q   <= '0;
      end else begin
         live_q <= 1'b1;
         open_q <= open_d;
         err_q  <= err_d;
         cfg_q  <= cfg_d;
         if (en) begin
            v1_q <= acc;
            f1_q <= acc & bus.A_tfirst;
            l1_q <= acc & bus.A_tlast;
            if (acc) begin
               ar_q <= bus.A_Re;
               ai_q <= bus.A_Im;
               br_q <= bus.B_Re;
               bi_q <= bus.B_Im;
               m1_q <= cfg_d;
            end
            rr_q  <= prod_t'(ar_q) * prod_t'(br_q);
            ii_q  <= prod_t'(ai_q) * prod_t'(bi_q);
            ri_q  <= prod_t'(ar_q) * prod_t'(bi_q);
            ir_q  <= prod_t'(ai_q) * prod_t'(br_q);
            v2_q  <= v1_q;
            f2_q  <= f1_q;
            l2_q  <= l1_q;
            m2_q  <= m1_q;
            cv_q  <= v2_q;
            cf_q  <= v2_q & f2_q;
            cl_q  <= v2_q & l2_q;
            ocv_q <= v2_q & f2_q;
            if (v2_q) begin
               cre_q <= cre_d;
               cim_q <= cim_d;
               if (f2_q)
                  om_q <= m2_q;
            end
         end
      end
   end
endmodule

// File: tb/tb_cmplx_mul.sv
// tb_cmplx_mul: vector table plus scoreboard for cmplx_mul.
// A 16-bit-output instance exercises saturation.
module tb_cmplx_mul;
   localparam int IW  = 16;
   localparam int OW  = 28;
   localparam int SOW = 16;

   typedef struct {
      logic signed [IW-1:0] ar, ai, br, bi;
      logic                 f, l;
      logic signed [OW-1:0] er, ei;
   } vec_t;

   typedef struct {
      logic signed [OW-1:0] re, im;
      logic                 f, l;
      logic [3:0]           m;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmplx_mul_if #(.IW(IW), .OW(OW))  bus ();
   cmplx_mul_if #(.IW(IW), .OW(SOW)) sbus ();

   cmplx_mul #(
      .InputBitWidth(IW), .OutputBitWidth(OW),
      .InputFractionalPoint(11), .OutputFractionalPoint(11)
   ) u_dut (.Clk(clk), .Reset(rst), .bus(bus));

   cmplx_mul #(
      .InputBitWidth(IW), .OutputBitWidth(SOW),
      .InputFractionalPoint(11), .OutputFractionalPoint(11)
   ) u_sat (.Clk(clk), .Reset(rst), .bus(sbus));

   exp_t       sb[$];
   exp_t       mon_e;
   int         n_run  = 0;
   int         n_fail = 0;
   int         n_last = 0;
   logic       stall_seen = 1'b0;
   logic [3:0] cur_mod = '0;
   vec_t       tbl[8];

`ifdef CMPLXMUL_ROUND_EN
   localparam int R_POS = 1;
   localparam int R_NEG = 0;
`else
   localparam int R_POS = 0;
   localparam int R_NEG = -1;
`endif

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int ar, input int ai,
                               input int br, input int bi,
                               input logic f, input logic l,
                               input int er, input int ei);
      vec_t v;
      v.ar = IW'(ar);
      v.ai = IW'(ai);
      v.br = IW'(br);
      v.bi = IW'(bi);
      v.f  = f;
      v.l  = l;
      v.er = OW'(er);
      v.ei = OW'(ei);
      return v;
   endfunction

   task automatic send(input vec_t v, input logic cv,
                       input logic [3:0] m);
      int   t;
      exp_t e;
      bus.A_Re           = v.ar;
      bus.A_Im           = v.ai;
      bus.B_Re           = v.br;
      bus.B_Im           = v.bi;
      bus.A_tfirst       = v.f;
      bus.A_tlast        = v.l;
      bus.A_tvalid       = 1'b1;
      bus.Cfg_tvalid     = cv;
      bus.Cfg_modulation = m;
      t = 0;
      @(negedge clk);
      while (!bus.A_tready && t < 100) begin
         if (cv && bus.Cfg_tready) cur_mod = m;
         @(negedge clk);
         t++;
      end
      if (cv && bus.Cfg_tready) cur_mod = m;
      if (!bus.A_tready) begin
         n_run++;
         n_fail++;
         $display("FAIL send_timeout: A_tready stuck at 0");
      end else begin
         e.re = v.er;
         e.im = v.ei;
         e.f  = v.f;
         e.l  = v.l;
         e.m  = cur_mod;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.A_tvalid   = 1'b0;
      bus.A_tfirst   = 1'b0;
      bus.A_tlast    = 1'b0;
      bus.Cfg_tvalid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_left", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Output checker; the head of the scoreboard is the beat on C.
   always @(negedge clk) begin
      if (!rst && bus.C_tvalid) begin
         if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL stale_beat: C_Re %0d with nothing expected",
                     bus.C_Re);
         end else if (!bus.C_tready) begin
            stall_seen = 1'b1;
            chk("stall_a_tready", bus.A_tready, 0);
            chk("stall_hold_re", bus.C_Re, sb[0].re);
            chk("stall_hold_im", bus.C_Im, sb[0].im);
            chk("stall_hold_last", bus.C_tlast, sb[0].l);
         end else begin
            mon_e = sb.pop_front();
            chk("c_re", bus.C_Re, mon_e.re);
            chk("c_im", bus.C_Im, mon_e.im);
            chk("c_first", bus.C_tfirst, mon_e.f);
            chk("c_last", bus.C_tlast, mon_e.l);
            chk("cfgout_valid", bus.CfgOut_tvalid, mon_e.f);
            if (mon_e.f)
               chk("cfgout_mod", bus.CfgOut_modulation, mon_e.m);
            if (bus.C_tlast) n_last++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      tbl[0] = mk(2048, 0, 2048, 0, 1'b1, 1'b0, 2048, 0);
      tbl[1] = mk(0, 2048, 0, 2048, 1'b0, 1'b0, -2048, 0);
      tbl[2] = mk(1024, 1024, 1024, -1024, 1'b0, 1'b0, 1024, 0);
      tbl[3] = mk(1, 0, 1024, 0, 1'b0, 1'b0, R_POS, 0);
      tbl[4] = mk(-1, 0, 1024, 0, 1'b0, 1'b0, R_NEG, 0);
      tbl[5] = mk(3000, -500, -1200, 700, 1'b0, 1'b0,
                  -1587, 1318);
      tbl[6] = mk(-32768, -32768, -32768, -32768, 1'b0, 1'b0,
                  0, 1048576);
      tbl[7] = mk(-32768, -32768, -32768, 32767, 1'b0, 1'b1,
                  1048560, 16);

      rst = 1'b1;
      bus.A_Re = '0; bus.A_Im = '0; bus.B_Re = '0; bus.B_Im = '0;
      bus.A_tvalid = 1'b0; bus.A_tfirst = 1'b0; bus.A_tlast = 1'b0;
      bus.Cfg_tvalid = 1'b0; bus.Cfg_modulation = '0;
      bus.C_tready = 1'b1;
      sbus.A_Re = '0; sbus.A_Im = '0; sbus.B_Re = '0; sbus.B_Im = '0;
      sbus.A_tvalid = 1'b0; sbus.A_tfirst = 1'b0; sbus.A_tlast = 1'b0;
      sbus.Cfg_tvalid = 1'b0; sbus.Cfg_modulation = '0;
      sbus.C_tready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_c_tvalid", bus.C_tvalid, 0);
      chk("rst_a_tready", bus.A_tready, 0);
      chk("rst_cfg_tready", bus.Cfg_tready, 0);
      chk("rst_err", bus.CmplxMul_Error, 0);
      chk("rst_cfgout_valid", bus.CfgOut_tvalid, 0);
      chk("rst_c_re", bus.C_Re, 0);
      chk("rst_cfgout_mod", bus.CfgOut_modulation, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_cfg_tready", bus.Cfg_tready, 1);
      chk("post_rst_a_tready", bus.A_tready, 1);
      @(posedge clk);
      #1;

      // Latency: single-beat packet, valid exactly 3 cycles later
      send(mk(2048, 0, 2048, 0, 1'b1, 1'b1, 2048, 0), 1'b1, 4'd3);
      @(negedge clk);
      chk("lat_cycle1", bus.C_tvalid, 0);
      @(negedge clk);
      chk("lat_cycle2", bus.C_tvalid, 0);
      @(negedge clk);
      chk("lat_cycle3", bus.C_tvalid, 1);
      drain();

      // Vector table as one packet
      for (int i = 0; i < 8; i++)
         send(tbl[i], (i == 0), 4'd9);
      drain();
      chk("table_err_clean", bus.CmplxMul_Error, 0);

      // Backpressure mid-packet
      n_last = 0;
      stall_seen = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(mk(256 * (i + 1), i, 2048, 0, (i == 0), (i == 7),
                       256 * (i + 1), i), (i == 0), 4'd6);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            bus.C_tready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            bus.C_tready = 1'b1;
         end
      join
      drain();
      chk("bp_stall_seen", stall_seen, 1);
      chk("bp_tlast_count", n_last, 1);
      chk("bp_err_clean", bus.CmplxMul_Error, 0);

      // Config is blocked while a packet is open
      send(mk(2048, 0, 2048, 0, 1'b1, 1'b0, 2048, 0), 1'b0, 4'd0);
      @(negedge clk);
      chk("cfg_tready_open", bus.Cfg_tready, 0);
      @(posedge clk);
      #1;

      // Reset mid-packet discards in-flight beats
      send(mk(512, 0, 2048, 0, 1'b0, 1'b0, 512, 0), 1'b0, 4'd0);
      rst = 1'b1;
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("midrst_c_tvalid", bus.C_tvalid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(mk(100, 200, 2048, 0, 1'b1, 1'b0, 100, 200), 1'b1, 4'd5);
      send(mk(-300, 40, 0, 2048, 1'b0, 1'b1, -40, -300), 1'b0, 4'd0);
      drain();
      chk("newpkt_err_clean", bus.CmplxMul_Error, 0);

      // Second tfirst without tlast flags an error
      send(mk(2048, 0, 4096, 0, 1'b1, 1'b0, 4096, 0), 1'b0, 4'd0);
      chk("dup_first_before", bus.CmplxMul_Error, 0);
      send(mk(2048, 0, 0, 4096, 1'b1, 1'b0, 0, 4096), 1'b0, 4'd0);
      chk("dup_first_err", bus.CmplxMul_Error, 1);
      send(mk(0, 2048, 0, 4096, 1'b0, 1'b1, -4096, 0), 1'b0, 4'd0);
      drain();
      chk("dup_first_sticky", bus.CmplxMul_Error, 1);

      // Saturation on the 16-bit-output instance
      do_reset();
      chk("sat_err_reset", sbus.CmplxMul_Error, 0);
      sbus.A_Re = 16'sd32767;
      sbus.B_Re = 16'sd32767;
      sbus.A_tfirst = 1'b1;
      sbus.A_tlast = 1'b1;
      sbus.A_tvalid = 1'b1;
      @(negedge clk);
      chk("sat_a_tready", sbus.A_tready, 1);
      @(posedge clk);
      #1;
      sbus.A_tvalid = 1'b0;
      t = 0;
      @(negedge clk);
      while (!sbus.C_tvalid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("sat_c_tvalid", sbus.C_tvalid, 1);
      chk("sat_c_re", sbus.C_Re, 32767);
      chk("sat_c_im", sbus.C_Im, 0);
      chk("sat_err", sbus.CmplxMul_Error, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("sat_err_sticky", sbus.CmplxMul_Error, 1);
      @(posedge clk);
      #1;
      do_reset();
      chk("sat_err_cleared", sbus.CmplxMul_Error, 0);
      chk("dut_err_cleared", bus.CmplxMul_Error, 0);

      // Beat without tfirst while no packet is open
      send(mk(2048, 0, 2048, 0, 1'b0, 1'b1, 2048, 0), 1'b0, 4'd0);
      chk("orphan_beat_err", bus.CmplxMul_Error, 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
